sram_dma: RTL and testbench

- Block-copy initiator that drives the single-port SRAM interface (addr, idata, odata, cs_, rw_) from the master side.
- Copies `len` words from `src` to `dst` in the same SRAM, one word at a time, as a read cycle followed by a write cycle.
- Sits between the control logic (start/done handshake) and the on-chip SRAM.
- Frees the control logic from sequencing word-by-word memory moves.

---
 rtl/sram_dma_pkg.sv | 25 ++
 rtl/sram_dma.sv | 127 ++++++++++++
 tb/tb_sram_dma.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_dma_pkg
// Purpose  : Shared widths, SRAM strobe encodings and DMA state encodings.
// Revision : 1.0
// ============================================================================
package sram_dma_pkg;

    localparam int   c_MEM_ADDR_WIDTH = 8;
    localparam int   c_DATA_WIDTH     = 8;

    localparam logic c_ENABLE_  = 1'b0;
    localparam logic c_DISABLE_ = 1'b1;
    localparam logic c_READ     = 1'b1;
    localparam logic c_WRITE    = 1'b0;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_READ  = 2'd1,
        DMA_WRITE = 2'd2,
        DMA_DONE  = 2'd3
    } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_dma.sv
`default_nettype none
// ============================================================================
// Module   : sram_dma
// Purpose  : Word-by-word SRAM block copy (read then write per word).
//            Optional XOR checksum port enabled by SRAM_DMA_CKSUM_EN.
// Revision : 1.0
// ============================================================================
module sram_dma
    import sram_dma_pkg::*;
#(
    parameter int ADDR_W = c_MEM_ADDR_WIDTH,
    parameter int DATA_W = c_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_cs_,
`ifdef SRAM_DMA_CKSUM_EN
    output logic [DATA_W-1:0] cksum,
`endif
    output logic              m_rw_
);

    dma_state_e        r_state;
    dma_state_e        w_next;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic [DATA_W-1:0] r_buf;
    logic              w_accept;

    assign w_accept = (r_state == DMA_IDLE) && start;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state     <= DMA_IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                DMA_IDLE: begin
                    if (start) begin
                        r_src_ptr   <= src;
                        r_dst_ptr   <= dst;
                        r_remaining <= len;
                    end
                end
                DMA_READ: begin
                    r_buf     <= m_rdata;
                    r_src_ptr <= r_src_ptr + ADDR_W'(1);
                end
                DMA_WRITE: begin
                    r_dst_ptr   <= r_dst_ptr + ADDR_W'(1);
                    r_remaining <= r_remaining - (ADDR_W + 1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Chip select is also gated by rst_ so a reset during WRITE aborts that word.
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        m_cs_   = c_DISABLE_;
        m_rw_   = c_READ;
        m_addr  = '0;
        m_wdata = '0;
        case (r_state)
            DMA_IDLE: begin
                if (start) w_next = (len == '0) ? DMA_DONE : DMA_READ;
            end
            DMA_READ: begin
                busy   = 1'b1;
                m_cs_  = rst_ ? c_ENABLE_ : c_DISABLE_;
                m_addr = r_src_ptr;
                w_next = DMA_WRITE;
            end
            DMA_WRITE: begin
                busy    = 1'b1;
                m_cs_   = rst_ ? c_ENABLE_ : c_DISABLE_;
                m_rw_   = c_WRITE;
                m_addr  = r_dst_ptr;
                m_wdata = r_buf;
                w_next  = (r_remaining == (ADDR_W + 1)'(1)) ? DMA_DONE : DMA_READ;
            end
            DMA_DONE: begin
                done   = 1'b1;
                w_next = DMA_IDLE;
            end
            default: w_next = DMA_IDLE;
        endcase
    end

`ifdef SRAM_DMA_CKSUM_EN
    logic [DATA_W-1:0] r_cksum;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_cksum <= '0;
        end else if (w_accept) begin
            r_cksum <= '0;
        end else if (r_state == DMA_READ) begin
            r_cksum <= r_cksum ^ m_rdata;
        end
    end

    assign cksum = r_cksum;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_dma
// Purpose  : Scoreboard bench for sram_dma with a behavioural SRAM responder.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sram_dma;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic          clk   = 1'b0;
    logic          rst_  = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src   = '0;
    logic [AW-1:0] dst   = '0;
    logic [AW:0]   len   = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_cs_;
    logic          m_rw_;
`ifdef SRAM_DMA_CKSUM_EN
    logic [DW-1:0] cksum;
`endif

    logic          pl_we   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    logic [DW-1:0] mem     [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    sram_dma #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk     (clk),
        .rst_    (rst_),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_cs_   (m_cs_),
`ifdef SRAM_DMA_CKSUM_EN
        .cksum   (cksum),
`endif
        .m_rw_   (m_rw_)
    );

    always #5 clk = ~clk;

    // SRAM responder: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (pl_we)                   mem[pl_addr] <= pl_data;
        else if (!m_cs_ && !m_rw_)   mem[m_addr]  <= m_wdata;
    end
    assign m_rdata = mem[m_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int a, input int d);
        @(negedge clk);
        pl_we   = 1'b1;
        pl_addr = AW'(a);
        pl_data = DW'(d);
        ref_mem[a] = DW'(d);
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic mem_check(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, mem[i], ref_mem[i]);
    endtask

    task automatic run_copy(input int s, input int d, input int n, input bit inject);
        int            done_cyc, done_cnt, busy_cnt, cs_cnt;
        wr_t           w;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] v;
`ifdef SRAM_DMA_CKSUM_EN
        logic [DW-1:0] ck;
        logic [DW-1:0] ck_at_done;
        ck = '0;
        ck_at_done = '1;
`endif
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; cs_cnt = 0;
        // Reference copy is sequential, so overlap semantics come out naturally.
        for (int i = 0; i < n; i++) begin
            ra = AW'(s + i);
            wa = AW'(d + i);
            v  = ref_mem[ra];
            rq.push_back(ra);
            w.a = wa;
            w.d = v;
            wq.push_back(w);
            ref_mem[wa] = v;
`ifdef SRAM_DMA_CKSUM_EN
            ck = ck ^ v;
`endif
        end
        @(negedge clk);
        start = 1'b1;
        src   = AW'(s);
        dst   = AW'(d);
        len   = (AW + 1)'(n);
        for (int k = 1; k <= 2 * n + 6; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
`ifdef SRAM_DMA_CKSUM_EN
                ck_at_done = cksum;
`endif
            end
`ifdef SRAM_DMA_CKSUM_EN
            if (k == 1) check("cksum_cleared", cksum, 0);
`endif
            if (!m_cs_) begin
                cs_cnt++;
                if (m_rw_) begin
                    check("rd_expected", rq.size() != 0, 1);
                    if (rq.size() != 0) check("rd_addr", m_addr, rq.pop_front());
                end else begin
                    check("wr_expected", wq.size() != 0, 1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        check("wr_addr", m_addr, w.a);
                        check("wr_data", m_wdata, w.d);
                    end
                end
            end
            if (k == 1) begin
                start = 1'b0;
                src   = ~src;
                dst   = ~dst;
                len   = ~len;
            end
            if (inject && (k == 3 || k == 2 * n + 1)) start = 1'b1;
            if (inject && (k == 6 || k == 2 * n + 2)) start = 1'b0;
        end
        check("done_cycle", done_cyc, 2 * n + 1);
        check("done_pulses", done_cnt, 1);
        check("busy_cycles", busy_cnt, 2 * n);
        check("cs_cycles", cs_cnt, 2 * n);
        check("queues_drained", rq.size() + wq.size(), 0);
`ifdef SRAM_DMA_CKSUM_EN
        check("cksum_at_done", ck_at_done, ck);
        check("cksum_held", cksum, ck);
`endif
        rq.delete();
        wq.delete();
    endtask

    task automatic reset_abort();
        int wr_cnt, done_cnt, cs_cnt;
        wr_cnt = 0; done_cnt = 0; cs_cnt = 0;
        ref_mem[16] = ref_mem[0];
        ref_mem[17] = ref_mem[1];
        @(negedge clk);
        start = 1'b1; src = 0; dst = 16; len = 4;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (!m_cs_ && !m_rw_ && k < 6) wr_cnt++;
            if (done) done_cnt++;
            if (k == 6) rst_ = 1'b0;
        end
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_cs", m_cs_, 1);
        check("abort_done", done, 0);
        check("abort_addr", m_addr, 0);
        check("abort_writes", wr_cnt, 2);
        rst_ = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!m_cs_) cs_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_cs", cs_cnt, 0);
        mem_check("abort_mem");
    endtask

    initial begin
        rst_ = 1'b0;
        for (int i = 0; i < DEPTH; i++) preload(i, (i * 37 + 5) & 255);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", m_cs_, 1);
        check("rst_rw", m_rw_, 1);
        check("rst_addr", m_addr, 0);
        check("rst_wdata", m_wdata, 0);
`ifdef SRAM_DMA_CKSUM_EN
        check("rst_cksum", cksum, 0);
`endif
        @(negedge clk);
        rst_ = 1'b1;

        preload(0, 11); preload(1, 22); preload(2, 33); preload(3, 44);
        run_copy(0, 16, 4, 1'b1);
        check("basic_m16", mem[16], 11);
        check("basic_m19", mem[19], 44);
        check("basic_src0", mem[0], 11);
        mem_check("basic_mem");

        run_copy(5, 20, 0, 1'b0);
        mem_check("zero_mem");

        run_copy(30, 2, 4, 1'b0);
        mem_check("wrap_mem");

        preload(0, 1); preload(1, 2); preload(2, 3); preload(3, 4);
        run_copy(0, 1, 3, 1'b0);
        check("ovl_up_m3", mem[3], 1);
        mem_check("ovl_up_mem");
        preload(0, 1); preload(1, 2); preload(2, 3); preload(3, 4);
        run_copy(1, 0, 3, 1'b0);
        check("ovl_dn_m2", mem[2], 4);
        mem_check("ovl_dn_mem");

        run_copy(10, 10, 3, 1'b0);
        mem_check("same_mem");

        run_copy(4, 20, 32, 1'b0);
        mem_check("full_mem");

        preload(8, 8'hA5); preload(9, 8'h0F); preload(10, 8'hFF);
        run_copy(8, 24, 3, 1'b0);
        mem_check("ck_mem");
        run_copy(0, 0, 0, 1'b0);

        preload(16, 8'h5A); preload(17, 8'h5B); preload(18, 8'h5C); preload(19, 8'h5D);
        reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
